// File: rtl/hyperram_arb_pkg.sv
// Shared types and constants for the two-master HyperRAM AXI arbiter.
package hyperram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic TYPE_WR = 1'b0;
    localparam logic TYPE_RD = 1'b1;

    // A zero timeout still needs a 1-bit counter so the declaration stays legal.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int TMO_W           = tmo_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/hyperram_arb_rr.sv
// Combinational round-robin picker: master alternates first, then read/write within the master.
module hyperram_arb_rr
    import hyperram_arb_pkg::*;
(
    input  logic [3:0] req,          // {m0_aw, m0_ar, m1_aw, m1_ar}
    input  logic       last_master,
    input  logic [1:0] last_type,    // per master, TYPE_RD / TYPE_WR
    output logic       pick_vld,
    output logic       pick_master,
    output logic       pick_type
);

    logic       other;
    logic       mst;
    logic [1:0] sel_req;

    always_comb begin
        pick_vld = |req;
        other    = ~last_master;
        mst      = other;
        if (other ? ~|req[1:0] : ~|req[3:2]) begin
            mst = last_master;
        end
        sel_req = mst ? req[1:0] : req[3:2];
        unique case (sel_req)
            2'b11:   pick_type = ~last_type[mst];
            2'b01:   pick_type = TYPE_RD;
            default: pick_type = TYPE_WR;
        endcase
        pick_master = mst;
    end

endmodule

// File: rtl/hyperram_axi_arbiter.sv
// Serialises whole AXI4 bursts from two masters onto the single HyperRAM controller port.
// One idle cycle per grant, zero added latency per beat; the idle master is held off with ready=0.
module hyperram_axi_arbiter
    import hyperram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    s_axi_aclk,
    input  logic                    reset,
    // master 0
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [0:0]              m0_awid,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [7:0]              m0_awlen,
    input  logic [2:0]              m0_awsize,
    input  logic [1:0]              m0_awburst,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wlast,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    output logic [0:0]              m0_bid,
    output logic [1:0]              m0_bresp,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    input  logic [0:0]              m0_arid,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [7:0]              m0_arlen,
    input  logic [2:0]              m0_arsize,
    input  logic [1:0]              m0_arburst,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    output logic [0:0]              m0_rid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rlast,
    // master 1
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [0:0]              m1_awid,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [7:0]              m1_awlen,
    input  logic [2:0]              m1_awsize,
    input  logic [1:0]              m1_awburst,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wlast,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    output logic [0:0]              m1_bid,
    output logic [1:0]              m1_bresp,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    input  logic [0:0]              m1_arid,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [7:0]              m1_arlen,
    input  logic [2:0]              m1_arsize,
    input  logic [1:0]              m1_arburst,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [0:0]              m1_rid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rlast,
    // HyperRAM controller slave port
    output logic                    hb_awvalid,
    input  logic                    hb_awready,
    output logic [0:0]              hb_awid,
    output logic [ADDR_WIDTH-1:0]   hb_awaddr,
    output logic [7:0]              hb_awlen,
    output logic [2:0]              hb_awsize,
    output logic [1:0]              hb_awburst,
    output logic                    hb_awlock,
    output logic [3:0]              hb_awregion,
    output logic [3:0]              hb_awcache,
    output logic [3:0]              hb_awqos,
    output logic [2:0]              hb_awprot,
    output logic                    hb_wvalid,
    input  logic                    hb_wready,
    output logic [DATA_WIDTH-1:0]   hb_wdata,
    output logic [DATA_WIDTH/8-1:0] hb_wstrb,
    output logic                    hb_wlast,
    input  logic                    hb_bvalid,
    output logic                    hb_bready,
    input  logic [0:0]              hb_bid,
    input  logic [1:0]              hb_bresp,
    output logic                    hb_arvalid,
    input  logic                    hb_arready,
    output logic [0:0]              hb_arid,
    output logic [ADDR_WIDTH-1:0]   hb_araddr,
    output logic [7:0]              hb_arlen,
    output logic [2:0]              hb_arsize,
    output logic [1:0]              hb_arburst,
    output logic                    hb_arlock,
    output logic [3:0]              hb_arregion,
    output logic [3:0]              hb_arcache,
    output logic [3:0]              hb_arqos,
    output logic [2:0]              hb_arprot,
    input  logic                    hb_rvalid,
    output logic                    hb_rready,
    input  logic [0:0]              hb_rid,
    input  logic [DATA_WIDTH-1:0]   hb_rdata,
    input  logic [1:0]              hb_rresp,
    input  logic                    hb_rlast,
    // status
    output logic [1:0]              grant,
    output logic                    busy,
    output logic                    error
);

    localparam int                CNT_W  = tmo_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TMO_M1 = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             sel;           // granted master, valid whenever busy
    logic [0:0]       gnt_id;
    logic             last_master;
    logic [1:0]       last_type;
    logic [CNT_W-1:0] cnt;
    logic             pick_vld, pick_master, pick_type;
    logic             in_aw, in_w, in_b, in_ar, in_r;

    hyperram_arb_rr u_rr (
        .req         ({m0_awvalid, m0_arvalid, m1_awvalid, m1_arvalid}),
        .last_master (last_master),
        .last_type   (last_type),
        .pick_vld    (pick_vld),
        .pick_master (pick_master),
        .pick_type   (pick_type)
    );

    always_ff @(posedge s_axi_aclk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_aw     = 1'b0;
        in_w      = 1'b0;
        in_b      = 1'b0;
        in_ar     = 1'b0;
        in_r      = 1'b0;
        unique case (state)
            S_IDLE: if (pick_vld) state_nxt = (pick_type == TYPE_RD) ? S_AR : S_AW;
            S_AW: begin
                in_aw = 1'b1;
                if (hb_awvalid && hb_awready) state_nxt = S_W;
            end
            S_W: begin
                in_w = 1'b1;
                if (hb_wvalid && hb_wready && hb_wlast) state_nxt = S_B;
            end
            S_B: begin
                in_b = 1'b1;
                if (hb_bvalid && hb_bready) state_nxt = S_IDLE;
            end
            S_AR: begin
                in_ar = 1'b1;
                if (hb_arvalid && hb_arready) state_nxt = S_R;
            end
            S_R: begin
                in_r = 1'b1;
                if (hb_rvalid && hb_rready && hb_rlast) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping and watchdog; the counter saturates so error stays a clean sticky flag.
    always_ff @(posedge s_axi_aclk or posedge reset) begin
        if (reset) begin
            sel         <= 1'b0;
            gnt_id      <= '0;
            last_master <= 1'b1;
            last_type   <= {TYPE_RD, TYPE_RD};
            cnt         <= '0;
            error       <= 1'b0;
        end else if (state == S_IDLE) begin
            if (pick_vld) begin
                sel                    <= pick_master;
                last_master            <= pick_master;
                last_type[pick_master] <= pick_type;
                cnt                    <= '0;
                if (pick_type == TYPE_RD) gnt_id <= pick_master ? m1_arid : m0_arid;
                else                      gnt_id <= pick_master ? m1_awid : m0_awid;
            end
        end else if (TIMEOUT != 0 && cnt != TMO) begin
            cnt <= cnt + 1'b1;
            if (cnt == TMO_M1) error <= 1'b1;
        end
    end

    assign busy  = (state != S_IDLE);
    assign grant = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;

    assign hb_awvalid  = in_aw & (sel ? m1_awvalid : m0_awvalid);
    assign hb_awid     = '0;
    assign hb_awaddr   = sel ? m1_awaddr  : m0_awaddr;
    assign hb_awlen    = sel ? m1_awlen   : m0_awlen;
    assign hb_awsize   = sel ? m1_awsize  : m0_awsize;
    assign hb_awburst  = sel ? m1_awburst : m0_awburst;
    assign hb_awlock   = 1'b0;
    assign hb_awregion = '0;
    assign hb_awcache  = '0;
    assign hb_awqos    = '0;
    assign hb_awprot   = '0;
    assign m0_awready  = in_aw & ~sel & hb_awready;
    assign m1_awready  = in_aw &  sel & hb_awready;

    assign hb_wvalid = in_w & (sel ? m1_wvalid : m0_wvalid);
    assign hb_wdata  = sel ? m1_wdata : m0_wdata;
    assign hb_wstrb  = sel ? m1_wstrb : m0_wstrb;
    assign hb_wlast  = sel ? m1_wlast : m0_wlast;
    assign m0_wready = in_w & ~sel & hb_wready;
    assign m1_wready = in_w &  sel & hb_wready;

    assign hb_bready = in_b & (sel ? m1_bready : m0_bready);
    assign m0_bvalid = in_b & ~sel & hb_bvalid;
    assign m1_bvalid = in_b &  sel & hb_bvalid;
    assign m0_bid    = gnt_id;
    assign m1_bid    = gnt_id;
    assign m0_bresp  = hb_bresp;
    assign m1_bresp  = hb_bresp;

    assign hb_arvalid  = in_ar & (sel ? m1_arvalid : m0_arvalid);
    assign hb_arid     = '0;
    assign hb_araddr   = sel ? m1_araddr  : m0_araddr;
    assign hb_arlen    = sel ? m1_arlen   : m0_arlen;
    assign hb_arsize   = sel ? m1_arsize  : m0_arsize;
    assign hb_arburst  = sel ? m1_arburst : m0_arburst;
    assign hb_arlock   = 1'b0;
    assign hb_arregion = '0;
    assign hb_arcache  = '0;
    assign hb_arqos    = '0;
    assign hb_arprot   = '0;
    assign m0_arready  = in_ar & ~sel & hb_arready;
    assign m1_arready  = in_ar &  sel & hb_arready;

    assign hb_rready = in_r & (sel ? m1_rready : m0_rready);
    assign m0_rvalid = in_r & ~sel & hb_rvalid;
    assign m1_rvalid = in_r &  sel & hb_rvalid;
    assign m0_rid    = gnt_id;
    assign m1_rid    = gnt_id;
    assign m0_rdata  = hb_rdata;
    assign m1_rdata  = hb_rdata;
    assign m0_rresp  = hb_rresp;
    assign m1_rresp  = hb_rresp;
    assign m0_rlast  = hb_rlast;
    assign m1_rlast  = hb_rlast;

    // Downstream ids are always 0; the masters get the id captured at grant instead.
    logic unused_hb_ids;
    assign unused_hb_ids = ^{hb_bid, hb_rid};

endmodule

// File: tb/tb_hyperram_axi_arbiter.sv
// Directed bench for hyperram_axi_arbiter: drives both masters and plays the HBMC by hand.
`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_hyperram_axi_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic m0_awvalid, m0_awready; logic [0:0] m0_awid; logic [31:0] m0_awaddr; logic [7:0] m0_awlen;
    logic [2:0] m0_awsize; logic [1:0] m0_awburst;
    logic m0_wvalid, m0_wready, m0_wlast; logic [31:0] m0_wdata; logic [3:0] m0_wstrb;
    logic m0_bvalid, m0_bready; logic [0:0] m0_bid; logic [1:0] m0_bresp;
    logic m0_arvalid, m0_arready; logic [0:0] m0_arid; logic [31:0] m0_araddr; logic [7:0] m0_arlen;
    logic [2:0] m0_arsize; logic [1:0] m0_arburst;
    logic m0_rvalid, m0_rready, m0_rlast; logic [0:0] m0_rid; logic [31:0] m0_rdata; logic [1:0] m0_rresp;

    logic m1_awvalid, m1_awready; logic [0:0] m1_awid; logic [31:0] m1_awaddr; logic [7:0] m1_awlen;
    logic [2:0] m1_awsize; logic [1:0] m1_awburst;
    logic m1_wvalid, m1_wready, m1_wlast; logic [31:0] m1_wdata; logic [3:0] m1_wstrb;
    logic m1_bvalid, m1_bready; logic [0:0] m1_bid; logic [1:0] m1_bresp;
    logic m1_arvalid, m1_arready; logic [0:0] m1_arid; logic [31:0] m1_araddr; logic [7:0] m1_arlen;
    logic [2:0] m1_arsize; logic [1:0] m1_arburst;
    logic m1_rvalid, m1_rready, m1_rlast; logic [0:0] m1_rid; logic [31:0] m1_rdata; logic [1:0] m1_rresp;

    logic hb_awvalid, hb_awready, hb_awlock; logic [0:0] hb_awid; logic [31:0] hb_awaddr; logic [7:0] hb_awlen;
    logic [2:0] hb_awsize, hb_awprot; logic [1:0] hb_awburst; logic [3:0] hb_awregion, hb_awcache, hb_awqos;
    logic hb_wvalid, hb_wready, hb_wlast; logic [31:0] hb_wdata; logic [3:0] hb_wstrb;
    logic hb_bvalid, hb_bready; logic [0:0] hb_bid; logic [1:0] hb_bresp;
    logic hb_arvalid, hb_arready, hb_arlock; logic [0:0] hb_arid; logic [31:0] hb_araddr; logic [7:0] hb_arlen;
    logic [2:0] hb_arsize, hb_arprot; logic [1:0] hb_arburst; logic [3:0] hb_arregion, hb_arcache, hb_arqos;
    logic hb_rvalid, hb_rready, hb_rlast; logic [0:0] hb_rid; logic [31:0] hb_rdata; logic [1:0] hb_rresp;

    logic [1:0] grant;
    logic busy, error;

    hyperram_axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4096)) dut (
        .s_axi_aclk(clk), .reset(reset),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr),
        .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid), .m0_bresp(m0_bresp),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .hb_awvalid(hb_awvalid), .hb_awready(hb_awready), .hb_awid(hb_awid), .hb_awaddr(hb_awaddr),
        .hb_awlen(hb_awlen), .hb_awsize(hb_awsize), .hb_awburst(hb_awburst), .hb_awlock(hb_awlock),
        .hb_awregion(hb_awregion), .hb_awcache(hb_awcache), .hb_awqos(hb_awqos), .hb_awprot(hb_awprot),
        .hb_wvalid(hb_wvalid), .hb_wready(hb_wready), .hb_wdata(hb_wdata), .hb_wstrb(hb_wstrb), .hb_wlast(hb_wlast),
        .hb_bvalid(hb_bvalid), .hb_bready(hb_bready), .hb_bid(hb_bid), .hb_bresp(hb_bresp),
        .hb_arvalid(hb_arvalid), .hb_arready(hb_arready), .hb_arid(hb_arid), .hb_araddr(hb_araddr),
        .hb_arlen(hb_arlen), .hb_arsize(hb_arsize), .hb_arburst(hb_arburst), .hb_arlock(hb_arlock),
        .hb_arregion(hb_arregion), .hb_arcache(hb_arcache), .hb_arqos(hb_arqos), .hb_arprot(hb_arprot),
        .hb_rvalid(hb_rvalid), .hb_rready(hb_rready), .hb_rid(hb_rid), .hb_rdata(hb_rdata),
        .hb_rresp(hb_rresp), .hb_rlast(hb_rlast),
        .grant(grant), .busy(busy), .error(error)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        {m0_awvalid, m0_awid, m0_awaddr, m0_awlen, m0_awsize, m0_awburst} = '0;
        {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m0_bready} = '0;
        {m0_arvalid, m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_rready} = '0;
        {m1_awvalid, m1_awid, m1_awaddr, m1_awlen, m1_awsize, m1_awburst} = '0;
        {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready} = '0;
        {m1_arvalid, m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_rready} = '0;
        {hb_bvalid, hb_bid, hb_bresp, hb_rvalid, hb_rid, hb_rdata, hb_rresp, hb_rlast} = '0;
        hb_awready = 1'b1;
        hb_wready  = 1'b1;
        hb_arready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    int beat, cyc, bad;

    initial begin
        clear_inputs();
        // reset state, with requests and HBMC readiness present
        m0_awvalid = 1'b1; m1_arvalid = 1'b1; hb_rvalid = 1'b1; m0_rready = 1'b1;
        #3;
        `CHK("rst grant", grant, 2'b00);
        `CHK("rst busy", busy, 1'b0);
        `CHK("rst error", error, 1'b0);
        `CHK("rst m0_awready", m0_awready, 1'b0);
        `CHK("rst hb_awvalid", hb_awvalid, 1'b0);
        `CHK("rst hb_arvalid", hb_arvalid, 1'b0);
        `CHK("rst m0_rvalid", m0_rvalid, 1'b0);
        `CHK("const hb_awlock/arprot", {hb_awlock, hb_awregion, hb_awcache, hb_awqos, hb_awprot,
                                        hb_arlock, hb_arregion, hb_arcache, hb_arqos, hb_arprot}, 0);
        clear_inputs();
        tick();
        reset = 1'b0;

        // m0 write, awlen=3, W beats offered before AW is granted
        tick();
        m0_awvalid = 1'b1; m0_awid = 1'b1; m0_awaddr = 32'h100; m0_awlen = 8'd3; m0_awsize = 3'd2;
        m0_awburst = 2'd1; m0_wvalid = 1'b1; m0_wdata = 32'hA0; m0_wstrb = 4'hF; m0_bready = 1'b1;
        settle();
        `CHK("t1 idle grant", grant, 2'b00);
        `CHK("t1 no comb grant", m0_awready, 1'b0);
        `CHK("t1 early wready idle", m0_wready, 1'b0);
        tick();
        `CHK("t1 grant", grant, 2'b01);
        `CHK("t1 busy", busy, 1'b1);
        `CHK("t1 hb_awvalid", hb_awvalid, 1'b1);
        `CHK("t1 hb_awaddr", hb_awaddr, 32'h100);
        `CHK("t1 hb_awlen", hb_awlen, 8'd3);
        `CHK("t1 hb_awid", hb_awid, 1'b0);
        `CHK("t1 m0_awready", m0_awready, 1'b1);
        `CHK("t1 early wready aw", m0_wready, 1'b0);
        `CHK("t1 hb_wvalid in aw", hb_wvalid, 1'b0);
        tick();
        m0_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_wdata = 32'hA0 + i;
            m0_wlast = (i == 3);
            settle();
            `CHK("t1 hb_wvalid", hb_wvalid, 1'b1);
            `CHK("t1 hb_wdata", hb_wdata, 32'hA0 + i);
            `CHK("t1 hb_wlast", hb_wlast, (i == 3));
            `CHK("t1 m0_wready", m0_wready, 1'b1);
            `CHK("t1 m1_awready", m1_awready, 1'b0);
            tick();
        end
        m0_wvalid = 1'b0; m0_wlast = 1'b0; hb_bvalid = 1'b1; hb_bresp = 2'd0;
        settle();
        `CHK("t1 m0_bvalid", m0_bvalid, 1'b1);
        `CHK("t1 m0_bid", m0_bid, 1'b1);
        `CHK("t1 m1_bvalid", m1_bvalid, 1'b0);
        `CHK("t1 hb_bready", hb_bready, 1'b1);
        tick();
        hb_bvalid = 1'b0;
        settle();
        `CHK("t1 end grant", grant, 2'b00);
        `CHK("t1 end busy", busy, 1'b0);

        // m0 read and m1 write together after reset: m0 first
        do_reset();
        m0_arvalid = 1'b1; m0_arid = 1'b0; m0_araddr = 32'h200; m0_arlen = 8'd0; m0_rready = 1'b1;
        m1_awvalid = 1'b1; m1_awid = 1'b1; m1_awaddr = 32'h300; m1_awlen = 8'd0; m1_bready = 1'b1;
        settle();
        `CHK("t2 grant idle", grant, 2'b00);
        tick();
        `CHK("t2 grant m0", grant, 2'b01);
        `CHK("t2 hb_arvalid", hb_arvalid, 1'b1);
        `CHK("t2 hb_araddr", hb_araddr, 32'h200);
        `CHK("t2 hb_awvalid", hb_awvalid, 1'b0);
        `CHK("t2 m1_awready held", m1_awready, 1'b0);
        tick();
        m0_arvalid = 1'b0; hb_rvalid = 1'b1; hb_rdata = 32'hD00D; hb_rlast = 1'b1;
        settle();
        `CHK("t2 m0_rvalid", m0_rvalid, 1'b1);
        `CHK("t2 m0_rdata", m0_rdata, 32'hD00D);
        `CHK("t2 m0_rid", m0_rid, 1'b0);
        `CHK("t2 m1_rvalid", m1_rvalid, 1'b0);
        tick();
        hb_rvalid = 1'b0; hb_rlast = 1'b0;
        settle();
        `CHK("t2 grant gap", grant, 2'b00);
        tick();
        `CHK("t2 grant m1", grant, 2'b10);
        `CHK("t2 hb_awaddr", hb_awaddr, 32'h300);
        `CHK("t2 m1_awready", m1_awready, 1'b1);
        `CHK("t2 m0_awready", m0_awready, 1'b0);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b1; m1_wdata = 32'hBEEF; m1_wstrb = 4'h3; m1_wlast = 1'b1;
        settle();
        `CHK("t2 hb_wdata", hb_wdata, 32'hBEEF);
        `CHK("t2 hb_wstrb", hb_wstrb, 4'h3);
        `CHK("t2 m1_wready", m1_wready, 1'b1);
        tick();
        m1_wvalid = 1'b0; hb_bvalid = 1'b1; hb_bresp = 2'd2;
        settle();
        `CHK("t2 m1_bvalid", m1_bvalid, 1'b1);
        `CHK("t2 m1_bid", m1_bid, 1'b1);
        `CHK("t2 m1_bresp", m1_bresp, 2'd2);
        `CHK("t2 m0_bvalid", m0_bvalid, 1'b0);
        tick();
        hb_bvalid = 1'b0;
        settle();
        `CHK("t2 end grant", grant, 2'b00);

        // m0 holds awvalid and arvalid: W,R,W,R
        do_reset();
        m0_awvalid = 1'b1; m0_awaddr = 32'h400; m0_arvalid = 1'b1; m0_araddr = 32'h500;
        m0_bready = 1'b1; m0_rready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            `CHK("t3 grant", grant, 2'b01);
            `CHK("t3 write turn", hb_awvalid, (t % 2 == 0));
            `CHK("t3 read turn", hb_arvalid, (t % 2 == 1));
            if (t % 2 == 0) begin
                tick();
                m0_wvalid = 1'b1; m0_wlast = 1'b1;
                tick();
                m0_wvalid = 1'b0; m0_wlast = 1'b0; hb_bvalid = 1'b1;
                tick();
                hb_bvalid = 1'b0;
            end else begin
                tick();
                hb_rvalid = 1'b1; hb_rlast = 1'b1;
                tick();
                hb_rvalid = 1'b0; hb_rlast = 1'b0;
            end
            settle();
            `CHK("t3 idle between", grant, 2'b00);
        end
        m0_awvalid = 1'b0; m0_arvalid = 1'b0;

        // 256-beat read with rready toggling every cycle
        m0_arvalid = 1'b1; m0_arid = 1'b1; m0_arlen = 8'd255;
        tick();
        tick();
        m0_arvalid = 1'b0;
        beat = 0; cyc = 0; bad = 0;
        while (beat < 256 && cyc < 2000) begin
            m0_rready = cyc[0];
            hb_rvalid = 1'b1; hb_rdata = 32'hC000 + beat; hb_rlast = (beat == 255);
            settle();
            if (hb_rready !== m0_rready) bad++;
            if (m0_rvalid && m0_rready) begin
                if (m0_rdata !== 32'hC000 + beat || m0_rlast !== (beat == 255) || m0_rid !== 1'b1) bad++;
                beat++;
            end
            tick();
            cyc++;
        end
        hb_rvalid = 1'b0; hb_rlast = 1'b0; m0_rready = 1'b1;
        settle();
        `CHK("t4 beats", beat, 256);
        `CHK("t4 beat errors", bad, 0);
        `CHK("t4 within budget", (cyc < 2000), 1'b1);
        `CHK("t4 back to idle", grant, 2'b00);

        // watchdog: bvalid withheld for 4100 cycles
        m0_awvalid = 1'b1; m0_awid = 1'b0; m0_awlen = 8'd0; m0_bready = 1'b1;
        tick();
        `CHK("t5 grant", grant, 2'b01);
        `CHK("t5 error at entry", error, 1'b0);
        tick();
        m0_awvalid = 1'b0; m0_wvalid = 1'b1; m0_wlast = 1'b1;
        tick();
        m0_wvalid = 1'b0; m0_wlast = 1'b0;
        for (int e = 3; e <= 4095; e++) tick();
        `CHK("t5 error before 4096", error, 1'b0);
        `CHK("t5 busy", busy, 1'b1);
        tick();
        `CHK("t5 error at 4096", error, 1'b1);
        for (int e = 4097; e <= 4100; e++) tick();
        `CHK("t5 still busy", busy, 1'b1);
        `CHK("t5 no bvalid yet", m0_bvalid, 1'b0);
        hb_bvalid = 1'b1;
        settle();
        `CHK("t5 m0_bvalid", m0_bvalid, 1'b1);
        tick();
        hb_bvalid = 1'b0;
        settle();
        `CHK("t5 idle busy", busy, 1'b0);
        `CHK("t5 idle grant", grant, 2'b00);
        `CHK("t5 error sticky", error, 1'b1);

        // reset mid read burst, then a fresh m1 read
        m0_arvalid = 1'b1; m0_arid = 1'b1; m0_arlen = 8'd3; m0_rready = 1'b1;
        tick();
        tick();
        m0_arvalid = 1'b0; hb_rvalid = 1'b1; hb_rdata = 32'h1; hb_rlast = 1'b0;
        settle();
        `CHK("t6 in R", m0_rvalid, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        `CHK("t6 rst m0_rvalid", m0_rvalid, 1'b0);
        `CHK("t6 rst hb_rready", hb_rready, 1'b0);
        `CHK("t6 rst grant", grant, 2'b00);
        `CHK("t6 rst busy", busy, 1'b0);
        `CHK("t6 rst error", error, 1'b0);
        clear_inputs();
        tick();
        reset = 1'b0;
        m1_arvalid = 1'b1; m1_arid = 1'b1; m1_araddr = 32'h600; m1_arlen = 8'd1; m1_rready = 1'b1;
        settle();
        tick();
        `CHK("t6 grant m1", grant, 2'b10);
        `CHK("t6 hb_araddr", hb_araddr, 32'h600);
        `CHK("t6 hb_arlen", hb_arlen, 8'd1);
        tick();
        m1_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hb_rvalid = 1'b1; hb_rdata = 32'hE0 + i; hb_rlast = (i == 1);
            settle();
            `CHK("t6 m1_rvalid", m1_rvalid, 1'b1);
            `CHK("t6 m1_rdata", m1_rdata, 32'hE0 + i);
            `CHK("t6 m1_rid", m1_rid, 1'b1);
            `CHK("t6 m0_rvalid", m0_rvalid, 1'b0);
            tick();
        end
        hb_rvalid = 1'b0; hb_rlast = 1'b0;
        settle();
        `CHK("t6 end grant", grant, 2'b00);
        `CHK("t6 end busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
